// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the MEM stage (master) and the data memory controller (slave).
// Both channels use valid/ready handshakes; the response carries read data and an error flag.
interface data_memory_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
);
  localparam int BE_W = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Parametrised data memory for the MEM stage: one outstanding access, WAIT_CYCLES extra cycles,
// per-byte write strobes, and misaligned/out-of-range rejection reported on the response channel.
module data_memory_ctrl #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  data_memory_ctrl_if.slave bus
);
  localparam int BE_W   = DATA_W / 8;
  localparam int OFS_W  = $clog2(BE_W);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int AW1    = ADDR_W + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [BE_W-1:0]   r_be;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept, w_commit, w_done, w_req_ready, w_resp_valid;
  logic [ADDR_W-1:0] w_idx;
  logic [MEM_AW-1:0] w_maddr;
  logic              w_misalign, w_oor, w_err;

  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_commit     = 1'b0;
    w_done       = 1'b0;
    w_req_ready  = 1'b0;
    w_resp_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (bus.req_valid) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_commit = 1'b1;
          w_next   = S_RESP;
        end
      end
      S_RESP: begin
        w_resp_valid = 1'b1;
        if (bus.resp_ready) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = w_resp_valid;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept)
        r_cnt <= CNT_W'(WAIT_CYCLES);
      else if (r_state == S_WAIT && r_cnt != '0)
        r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Request fields are data only; they are qualified by the state machine.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we    <= bus.req_we;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_be    <= bus.req_be;
    end
  end

  assign w_idx      = r_addr >> OFS_W;
  assign w_misalign = (r_addr & ADDR_W'(BE_W - 1)) != '0;
  assign w_oor      = {1'b0, w_idx} >= AW1'(DEPTH);
  assign w_err      = w_misalign | w_oor;
  assign w_maddr    = w_idx[MEM_AW-1:0];

  // The array is never reset; a write lands only on the commit edge, so a reset abort drops it.
  always_ff @(posedge clk) begin
    if (w_commit && r_we && !w_err) begin
      for (int i = 0; i < BE_W; i++) begin
        if (r_be[i]) r_mem[w_maddr][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_commit) begin
      r_err   <= w_err;
      r_rdata <= (!r_we && !w_err) ? r_mem[w_maddr] : '0;
    end else if (w_done) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: two instances (WAIT_CYCLES=2 and 0) share one stimulus
// port selected by sel; expected responses go through a FIFO scoreboard.
module tb_data_memory_ctrl;
  logic clk;
  logic rst2_n, rst0_n;
  int   sel;
  int   errors = 0;
  int   checks = 0;

  logic        t_req_valid, t_req_we, t_resp_ready;
  logic [11:0] t_req_addr;
  logic [31:0] t_req_wdata;
  logic [3:0]  t_req_be;
  logic        w_req_ready, w_resp_valid, w_resp_err;
  logic [31:0] w_resp_rdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(12)) if2 ();
  data_memory_ctrl_if #(.DATA_W(32), .ADDR_W(12)) if0 ();

  data_memory_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst2_n), .bus(if2.slave));
  data_memory_ctrl #(.DATA_W(32), .DEPTH(256), .ADDR_W(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(if0.slave));

  assign if2.req_valid  = (sel == 2) ? t_req_valid  : 1'b0;
  assign if0.req_valid  = (sel == 0) ? t_req_valid  : 1'b0;
  assign if2.resp_ready = (sel == 2) ? t_resp_ready : 1'b0;
  assign if0.resp_ready = (sel == 0) ? t_resp_ready : 1'b0;
  assign if2.req_we = t_req_we;  assign if0.req_we = t_req_we;
  assign if2.req_addr = t_req_addr;  assign if0.req_addr = t_req_addr;
  assign if2.req_wdata = t_req_wdata;  assign if0.req_wdata = t_req_wdata;
  assign if2.req_be = t_req_be;  assign if0.req_be = t_req_be;

  assign w_req_ready  = (sel == 2) ? if2.req_ready  : if0.req_ready;
  assign w_resp_valid = (sel == 2) ? if2.resp_valid : if0.resp_valid;
  assign w_resp_rdata = (sel == 2) ? if2.resp_rdata : if0.resp_rdata;
  assign w_resp_err   = (sel == 2) ? if2.resp_err   : if0.resp_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                          input bit push, input string tag);
    int n = 0;
    @(negedge clk);
    t_req_valid = 1'b1; t_req_we = we; t_req_addr = addr; t_req_wdata = wd; t_req_be = be;
    while (!w_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, w_req_ready, 1);
    if (push) sb_q.push_back('{exp_rd, exp_err, (sel == 2) ? 3 : 1, tag});
    @(posedge clk); #1;
    t_req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    exp_t e;
    int   lat = 0;
    while (!w_resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard: observed response with empty queue, expected none");
    end else begin
      e = sb_q.pop_front();
      chk({e.tag, "_latency"}, lat, e.lat);
      chk({e.tag, "_valid"}, w_resp_valid, 1);
      chk({e.tag, "_rdata"}, w_resp_rdata, e.rdata);
      chk({e.tag, "_err"}, w_resp_err, e.err);
    end
  endtask

  task automatic finish_resp(input string tag);
    @(negedge clk);
    t_resp_ready = 1'b1;
    @(posedge clk); #1;
    t_resp_ready = 1'b0;
    chk({tag, "_hs_valid"}, w_resp_valid, 0);
    chk({tag, "_hs_rdata"}, w_resp_rdata, 0);
  endtask

  task automatic txn(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic [31:0] exp_rd, input logic exp_err,
                     input string tag);
    send_req(we, addr, wd, be, exp_rd, exp_err, 1'b1, tag);
    wait_resp();
    finish_resp(tag);
  endtask

  task automatic abort_write(input string tag);
    send_req(1'b1, 12'h020, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b0, tag);
    @(negedge clk);
    if (sel == 2) rst2_n = 1'b0; else rst0_n = 1'b0;
    #1;
    chk({tag, "_rst_ready"}, w_req_ready, 1);
    chk({tag, "_rst_valid"}, w_resp_valid, 0);
    chk({tag, "_rst_rdata"}, w_resp_rdata, 0);
    chk({tag, "_rst_err"}, w_resp_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst2_n = 1'b1; rst0_n = 1'b1;
  endtask

  initial begin
    sel = 2;
    rst2_n = 1'b0; rst0_n = 1'b0;
    t_req_valid = 1'b1; t_req_we = 1'b1; t_req_addr = 12'h010;
    t_req_wdata = 32'h55555555; t_req_be = 4'hF; t_resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", w_req_ready, 1);
    chk("rst_valid", w_resp_valid, 0);
    chk("rst_rdata", w_resp_rdata, 0);
    chk("rst_err", w_resp_err, 0);
    chk("rst0_ready", if0.req_ready, 1);
    chk("rst0_valid", if0.resp_valid, 0);
    @(negedge clk);
    rst2_n = 1'b1; rst0_n = 1'b1; t_req_valid = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ready", w_req_ready, 1);
    chk("post_rst_valid", w_resp_valid, 0);

    // Full write / read with two wait states
    txn(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, "wr_full");
    txn(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, "rd_full");

    // Byte lanes
    txn(1'b1, 12'h010, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, "wr_lane1");
    txn(1'b0, 12'h010, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, "rd_lane1");
    txn(1'b1, 12'h010, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, "wr_be0");
    txn(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, "rd_be0");

    // Errors
    txn(1'b0, 12'h011, 32'h0, 4'hF, 32'h0, 1'b1, "rd_misalign");
    txn(1'b1, 12'h013, 32'h12345678, 4'hF, 32'h0, 1'b1, "wr_misalign");
    txn(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, "rd_after_err");
    txn(1'b0, 12'h400, 32'h0, 4'h0, 32'h0, 1'b1, "rd_oor");

    // Backpressure with a competing request held during RESP
    send_req(1'b0, 12'h010, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, 1'b1, "bp_rd");
    wait_resp();
    @(negedge clk);
    t_req_valid = 1'b1; t_req_we = 1'b0; t_req_addr = 12'h010; t_req_be = 4'h0;
    sb_q.push_back('{32'hDEADAAEF, 1'b0, 3, "bp_next"});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", w_resp_valid, 1);
      chk("bp_rdata", w_resp_rdata, 32'hDEADAAEF);
      chk("bp_ready", w_req_ready, 0);
    end
    @(negedge clk);
    t_resp_ready = 1'b1;
    @(posedge clk); #1;
    t_resp_ready = 1'b0;
    chk("bp_idle_ready", w_req_ready, 1);
    chk("bp_idle_valid", w_resp_valid, 0);
    @(posedge clk); #1;
    t_req_valid = 1'b0;
    chk("bp_next_accepted", w_req_ready, 0);
    wait_resp();
    finish_resp("bp_next");

    // Reset abort during WAIT, two wait states
    txn(1'b1, 12'h020, 32'h00000000, 4'hF, 32'h0, 1'b0, "w2_clear");
    abort_write("w2_abort");
    txn(1'b0, 12'h020, 32'h0, 4'h0, 32'h00000000, 1'b0, "w2_rd_abort");

    // Same on the zero-wait instance; latency there is one edge
    sel = 0;
    txn(1'b1, 12'h020, 32'h00000000, 4'hF, 32'h0, 1'b0, "w0_clear");
    txn(1'b1, 12'h024, 32'hA5A5F00F, 4'hF, 32'h0, 1'b0, "w0_wr");
    txn(1'b0, 12'h024, 32'h0, 4'h0, 32'hA5A5F00F, 1'b0, "w0_rd");
    abort_write("w0_abort");
    txn(1'b0, 12'h020, 32'h0, 4'h0, 32'h00000000, 1'b0, "w0_rd_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised data memory for the pipeline's MEM stage.
- Generalises the fixed 8-bit single-cycle data memory with configurable data width, depth, wait states and per-byte write strobes.
- Uses a valid/ready request channel and a valid/ready response channel with error reporting.
- The MEM stage holds its request until accepted, then stalls until the response is taken.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- DEPTH, 256, number of DATA_W-bit words.
- ADDR_W, 12, byte-address width; must satisfy 2^ADDR_W >= DEPTH*(DATA_W/8).
- WAIT_CYCLES, 1, extra access cycles inserted before each response; 0 is legal.
- Derived, not overridable: BE_W = DATA_W/8; OFS_W = log2(BE_W).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_be  in  BE_W  byte-lane write enables; bit i controls bits [8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer takes response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  access rejected (misaligned or out of range).

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0.
- Reset does not clear the memory array.
- Reset assertion aborts any in-flight request. An uncommitted write is never performed.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready at edge N, latch we/addr/wdata/be, load counter=WAIT_CYCLES, go to WAIT.
  - WAIT: req_ready=0. Each edge with counter!=0 decrements it. At the edge with counter==0, commit the access and go to RESP.
  - RESP: resp_valid=1, req_ready=0. At the edge with resp_ready=1, clear resp_valid/resp_err/resp_rdata to 0 and go to IDLE.
- Latency: request accepted at edge N gives resp_valid=1 after edge N+1+WAIT_CYCLES.
- Earliest next acceptance is the edge after the response handshake. req_ready is 0 from acceptance until re-entry to IDLE.
- Address decode: word index = req_addr[ADDR_W-1:OFS_W].
  - Misaligned if req_addr[OFS_W-1:0] != 0.
  - Out of range if word index >= DEPTH.
  - Either condition sets resp_err=1 and resp_rdata=0. No array write occurs.
- Commit for a write:
  - Only lanes with req_be[i]=1 are updated.
  - be all-zero is a legal no-op with resp_err=0.
  - resp_rdata=0.
- Commit for a read: resp_rdata = full word at the commit edge; req_be is ignored.
- Backpressure: resp_valid, resp_rdata and resp_err stay stable while resp_valid=1 and resp_ready=0.
- req_valid is ignored outside IDLE; there are no queued requests.
- Read after write to the same word returns the written data; the write is committed before the following request is accepted.
- All arithmetic is unsigned. The counter is wide enough for WAIT_CYCLES and never wraps.

Test Plan:
1. Reset: hold rst_n=0 3 cycles with req_valid=1, then release -> req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. No access occurs during reset.
2. Full write/read, WAIT_CYCLES=2:
   - Write 0xDEADBEEF to 0x010, be=4'b1111, accepted at edge N -> resp_valid=1 after edge N+3, resp_err=0, resp_rdata=0.
   - Read 0x010 -> resp_rdata=0xDEADBEEF.
3. Byte lanes: write 0x0000AA00 to 0x010 with be=4'b0010 -> read 0x010 returns 0xDEADAAEF. A write with be=4'b0000 leaves 0xDEADAAEF unchanged and resp_err=0.
4. Errors:
   - Read 0x011 -> resp_err=1, resp_rdata=0.
   - Write 0x12345678 to 0x013 -> resp_err=1; a subsequent read of 0x010 is still 0xDEADAAEF.
   - Read 0x400 (word 256) -> resp_err=1.
5. Backpressure: read 0x010 with resp_ready=0 for 5 cycles -> resp_valid=1 and resp_rdata=0xDEADAAEF stable, req_ready=0. A competing req_valid is ignored. resp_ready=1 gives IDLE on the next edge, and the next request is accepted one edge later.
6. Reset mid-operation: write 0xCAFEF00D to 0x020 (prior contents 0x00000000), assert rst_n during WAIT -> outputs return to reset values immediately. A subsequent read of 0x020 returns 0x00000000. Repeat with WAIT_CYCLES=0: latency is exactly 1 edge after acceptance.
